// File: rtl/hpm_counter_ctrl.sv
// ---------------------------------------------------------------------------
// hpm_counter_ctrl
//
// Control front-end for a bank of hardware performance counters. It decodes
// a simple req/gnt CSR port into counter-bank write strobes, keeps the event
// select and inhibit configuration, and turns selected event strobes into
// per-counter increment pulses.
//
// Ports
//   clk_i, rst_i     clock, synchronous active-high reset
//   csr_req_i        access request (accepted when csr_gnt_o is high)
//   csr_we_i         1 = write, 0 = read
//   csr_addr_i       [6:5] space: 00 counter low, 01 counter high,
//                    10 event select, 11 inhibit; [4:0] counter index
//   csr_wdata_i      write data
//   csr_gnt_o        request accepted this cycle
//   csr_rvalid_o     one-cycle response strobe
//   csr_rdata_o      read data, valid with csr_rvalid_o
//   csr_err_o        access error, valid with csr_rvalid_o
//   event_i          per-cycle event strobes
//   counter_rd_i     current bank values, slot i at [i*64 +: 64]
//   counter_inc_o    registered increment strobes to the bank
//   counter_we_o     low-half write strobes
//   counterh_we_o    high-half write strobes
//   counter_wval_o   write value to the bank (0 outside a write)
// ---------------------------------------------------------------------------
module hpm_counter_ctrl #(
    parameter int unsigned MaxNumCounters = 29,
    parameter int unsigned NumCounters    = 3,
    parameter int unsigned NumEvents      = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         csr_req_i,
    input  logic                         csr_we_i,
    input  logic [6:0]                   csr_addr_i,
    input  logic [31:0]                  csr_wdata_i,
    output logic                         csr_gnt_o,
    output logic                         csr_rvalid_o,
    output logic [31:0]                  csr_rdata_o,
    output logic                         csr_err_o,
    input  logic [NumEvents-1:0]         event_i,
    input  logic [MaxNumCounters*64-1:0] counter_rd_i,
    output logic [MaxNumCounters-1:0]    counter_inc_o,
    output logic [MaxNumCounters-1:0]    counter_we_o,
    output logic [MaxNumCounters-1:0]    counterh_we_o,
    output logic [31:0]                  counter_wval_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam logic [1:0] SP_LO  = 2'b00;
    localparam logic [1:0] SP_HI  = 2'b01;
    localparam logic [1:0] SP_SEL = 2'b10;

    state_e state_q, state_d;

    // Latched request. The direction is held by the WRITE/READ state itself.
    logic [6:0]  addr_q;
    logic [31:0] wdata_q;

    logic [31:0] rdata_q;
    logic        err_q;

    logic [3:0]             evsel_q [NumCounters];
    logic [NumCounters-1:0] inhibit_q;

    // Shadow of the high half captured by a low-half read, so a low/high
    // read pair returns a consistent 64-bit snapshot.
    logic [31:0] shadow_q;
    logic [4:0]  shadow_idx_q;
    logic        shadow_vld_q;

    logic [MaxNumCounters-1:0] inc_q, inc_d;

    logic [1:0]  space;
    logic [4:0]  idx;
    logic        acc_err;
    logic [63:0] slot_val;
    logic [3:0]  slot_evsel;
    logic [3:0]  evsel_new;
    logic [15:0] ev_ext;
    logic [31:0] inh_ext;
    logic [31:0] rd_val;
    logic        wr_cycle;

    assign space = addr_q[6:5];
    assign idx   = addr_q[4:0];

    // Inhibit space has no index; every other space needs an implemented slot.
    assign acc_err = (space != 2'b11) && (32'(idx) >= NumCounters);

    // Out-of-range select values fall back to event 0.
    assign evsel_new = (32'(wdata_q[3:0]) < NumEvents) ? wdata_q[3:0] : 4'd0;

    // Bits of the bank and write data that no implemented counter uses.
    logic unused_inputs;
    assign unused_inputs = ^{counter_rd_i, wdata_q};

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (csr_req_i) state_d = csr_we_i ? WRITE : READ;
            WRITE:   state_d = RESP;
            READ:    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------------
    always_comb begin
        csr_gnt_o    = (state_q == IDLE);
        csr_rvalid_o = (state_q == RESP);
        csr_err_o    = (state_q == RESP) && err_q;
        csr_rdata_o  = rdata_q;

        // Reset landing in the WRITE cycle kills the strobe before it leaves.
        wr_cycle = (state_q == WRITE) && !rst_i;

        counter_we_o  = '0;
        counterh_we_o = '0;
        for (int i = 0; i < NumCounters; i++) begin
            if (idx == 5'(i)) begin
                counter_we_o[i]  = wr_cycle && !acc_err && (space == SP_LO);
                counterh_we_o[i] = wr_cycle && !acc_err && (space == SP_HI);
            end
        end
        counter_wval_o = wr_cycle ? wdata_q : 32'd0;

        // A software write to a counter wins over a same-cycle increment.
        counter_inc_o = inc_q & ~(counter_we_o | counterh_we_o);
    end

    // ---------------------------------------------------------------------
    // Read mux and event fan-in
    // ---------------------------------------------------------------------
    always_comb begin
        ev_ext = '0;
        ev_ext[NumEvents-1:0] = event_i;
        inh_ext = '0;
        inh_ext[NumCounters-1:0] = inhibit_q;
    end

    always_comb begin
        slot_val   = '0;
        slot_evsel = '0;
        for (int i = 0; i < NumCounters; i++) begin
            if (idx == 5'(i)) begin
                slot_val   = counter_rd_i[i*64 +: 64];
                slot_evsel = evsel_q[i];
            end
        end

        rd_val = '0;
        unique case (space)
            SP_LO:   rd_val = slot_val[31:0];
            SP_HI:   rd_val = (shadow_vld_q && (shadow_idx_q == idx)) ? shadow_q
                                                                      : slot_val[63:32];
            SP_SEL:  rd_val = {28'd0, slot_evsel};
            default: rd_val = inh_ext;
        endcase
    end

    always_comb begin
        inc_d = '0;
        for (int i = 0; i < NumCounters; i++) begin
            inc_d[i] = ev_ext[evsel_q[i]] && !inhibit_q[i];
        end
    end

    // ---------------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            inhibit_q    <= '0;
            shadow_q     <= '0;
            shadow_idx_q <= '0;
            shadow_vld_q <= 1'b0;
            inc_q        <= '0;
            for (int i = 0; i < NumCounters; i++) begin
                evsel_q[i] <= '0;
            end
        end else begin
            inc_q <= inc_d;

            if ((state_q == IDLE) && csr_req_i) begin
                addr_q  <= csr_addr_i;
                wdata_q <= csr_wdata_i;
            end

            if (state_q == WRITE) begin
                err_q   <= acc_err;
                rdata_q <= '0;
                if (!acc_err) begin
                    unique case (space)
                        SP_LO, SP_HI: shadow_vld_q <= 1'b0;
                        SP_SEL: begin
                            for (int i = 0; i < NumCounters; i++) begin
                                if (idx == 5'(i)) evsel_q[i] <= evsel_new;
                            end
                        end
                        default: inhibit_q <= wdata_q[NumCounters-1:0];
                    endcase
                end
            end

            if (state_q == READ) begin
                err_q   <= acc_err;
                rdata_q <= acc_err ? 32'd0 : rd_val;
                if (!acc_err) begin
                    if (space == SP_LO) begin
                        shadow_q     <= slot_val[63:32];
                        shadow_idx_q <= idx;
                        shadow_vld_q <= 1'b1;
                    end else if (space == SP_HI) begin
                        shadow_vld_q <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_hpm_counter_ctrl.sv
module tb_hpm_counter_ctrl;
    localparam int MAXN = 29;
    localparam int NC   = 3;
    localparam int NE   = 8;

    logic                 clk_i = 1'b0;
    logic                 rst_i = 1'b1;
    logic                 csr_req_i = 1'b0;
    logic                 csr_we_i = 1'b0;
    logic [6:0]           csr_addr_i = '0;
    logic [31:0]          csr_wdata_i = '0;
    logic                 csr_gnt_o, csr_rvalid_o, csr_err_o;
    logic [31:0]          csr_rdata_o;
    logic [NE-1:0]        event_i = '0;
    logic [MAXN*64-1:0]   counter_rd_i;
    logic [MAXN-1:0]      counter_inc_o, counter_we_o, counterh_we_o;
    logic [31:0]          counter_wval_o;

    logic [63:0] bank [MAXN];

    always_comb begin
        for (int i = 0; i < MAXN; i++) counter_rd_i[i*64 +: 64] = bank[i];
    end

    hpm_counter_ctrl #(
        .MaxNumCounters(MAXN), .NumCounters(NC), .NumEvents(NE)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .csr_req_i(csr_req_i), .csr_we_i(csr_we_i), .csr_addr_i(csr_addr_i),
        .csr_wdata_i(csr_wdata_i), .csr_gnt_o(csr_gnt_o), .csr_rvalid_o(csr_rvalid_o),
        .csr_rdata_o(csr_rdata_o), .csr_err_o(csr_err_o), .event_i(event_i),
        .counter_rd_i(counter_rd_i), .counter_inc_o(counter_inc_o),
        .counter_we_o(counter_we_o), .counterh_we_o(counterh_we_o),
        .counter_wval_o(counter_wval_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Model state: configuration as software sees it, shadow snapshot,
    // and the write strobes the current transaction should produce.
    logic [3:0]      m_evsel [NC];
    logic [NC-1:0]   m_inh = '0;
    bit              m_shvld = 1'b0;
    int              m_shidx = 0;
    logic [31:0]     m_sh = '0;
    logic [MAXN-1:0] pend_q = '0;
    logic [MAXN-1:0] exp_we = '0, exp_weh = '0;
    logic [31:0]     exp_wval = '0;
    logic [MAXN-1:0] last_we, last_inc;
    logic [31:0]     last_wval;
    logic [31:0]     got;
    int              cnt, first_k;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Each cycle: the increment seen now is what the previous cycle's events,
    // filtered by the configuration in force then, asked for, minus any
    // counter being written right now.
    always @(negedge clk_i) begin
        logic [MAXN-1:0] nxt;
        chk("inc", counter_inc_o, pend_q & ~(exp_we | exp_weh));
        chk("we", counter_we_o, exp_we);
        chk("weh", counterh_we_o, exp_weh);
        chk("wval", counter_wval_o, exp_wval);
        nxt = '0;
        for (int i = 0; i < NC; i++) nxt[i] = !rst_i && event_i[m_evsel[i]] && !m_inh[i];
        pend_q = nxt;
    end

    task automatic csr(input bit we, input logic [1:0] sp, input int idx,
                       input logic [31:0] wd, output logic [31:0] rd);
        bit          err;
        logic [31:0] er;
        int          w;
        err = (sp != 2'd3) && (idx >= NC);
        csr_req_i = 1'b1; csr_we_i = we; csr_addr_i = {sp, 5'(idx)}; csr_wdata_i = wd;
        w = 0;
        while (!csr_gnt_o && w < 8) begin tick(); w++; end
        chk("gnt_wait", 64'(w < 8), 64'd1);
        tick();
        csr_req_i = 1'b0;
        if (we && !err && sp == 2'd0) exp_we[idx] = 1'b1;
        if (we && !err && sp == 2'd1) exp_weh[idx] = 1'b1;
        exp_wval = we ? wd : 32'd0;
        #1;
        last_we = counter_we_o; last_wval = counter_wval_o; last_inc = counter_inc_o;
        chk("gnt_busy", csr_gnt_o, 0);
        chk("rvalid_early", csr_rvalid_o, 0);
        tick();
        exp_we = '0; exp_weh = '0; exp_wval = '0;
        er = '0;
        if (!err) begin
            if (we) begin
                case (sp)
                    2'd0, 2'd1: m_shvld = 1'b0;
                    2'd2: m_evsel[idx] = (wd[3:0] < NE) ? wd[3:0] : 4'd0;
                    default: m_inh = wd[NC-1:0];
                endcase
            end else begin
                case (sp)
                    2'd0: begin
                        er = bank[idx][31:0];
                        m_sh = bank[idx][63:32]; m_shidx = idx; m_shvld = 1'b1;
                    end
                    2'd1: begin
                        er = (m_shvld && m_shidx == idx) ? m_sh : bank[idx][63:32];
                        m_shvld = 1'b0;
                    end
                    2'd2: er = {28'd0, m_evsel[idx]};
                    default: er = 32'(m_inh);
                endcase
            end
        end
        chk("rvalid", csr_rvalid_o, 1);
        chk("err", csr_err_o, err);
        if (!we) chk("rdata", csr_rdata_o, er);
        rd = csr_rdata_o;
        tick();
        chk("rvalid_one_cycle", csr_rvalid_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NC; i++) m_evsel[i] = '0;
        for (int i = 0; i < MAXN; i++) bank[i] = {32'h1000_0000 + 32'(i), 32'hA000_0000 + 32'(i)};
        repeat (2) tick();
        rst_i = 1'b0;
        #1;
        chk("rst_gnt", csr_gnt_o, 1);
        chk("rst_rvalid", csr_rvalid_o, 0);
        chk("rst_err", csr_err_o, 0);
        chk("rst_rdata", csr_rdata_o, 0);
        tick();

        // Low-half write strobe
        csr(1, 2'd0, 1, 32'hDEADBEEF, got);
        chk("r23_we", last_we, 64'h2);
        chk("r23_wval", last_wval, 64'hDEADBEEF);
        csr(1, 2'd1, 0, 32'h1234_5678, got);
        csr(0, 2'd3, 0, 0, got);
        csr(0, 2'd2, 2, 0, got);

        // Shadowed high-half read
        bank[2] = 64'h0000_0001_FFFF_FFFF;
        csr(0, 2'd0, 2, 0, got);
        chk("r24_lo", got, 64'hFFFFFFFF);
        bank[2] = 64'h0000_0002_0000_0000;
        csr(0, 2'd1, 2, 0, got);
        chk("r24_hi_shadow", got, 64'h1);
        csr(0, 2'd1, 2, 0, got);
        chk("r24_hi_live", got, 64'h2);
        csr(0, 2'd0, 2, 0, got);
        csr(1, 2'd0, 2, 32'h3, got);
        bank[2] = 64'h0000_0007_0000_0003;
        csr(0, 2'd1, 2, 0, got);
        chk("shadow_cleared_by_write", got, 64'h7);
        csr(0, 2'd0, 0, 0, got);
        csr(0, 2'd1, 1, 0, got);
        chk("shadow_idx_mismatch", got, 64'h1000_0001);

        // Event select and inhibit
        csr(1, 2'd2, 0, 32'd3, got);
        csr(1, 2'd3, 0, 32'd0, got);
        cnt = 0; first_k = -1;
        for (int k = 0; k < 8; k++) begin
            tick();
            event_i = (k < 5) ? 8'h08 : 8'h00;
            #1;
            if (counter_inc_o[0]) begin
                cnt++;
                if (first_k < 0) first_k = k;
            end
        end
        chk("r25_count", 64'(cnt), 64'd5);
        chk("r25_latency", 64'(first_k), 64'd1);
        tick();
        event_i = 8'h08;
        tick(); tick();
        chk("r25_on", counter_inc_o, 64'h1);
        csr(1, 2'd3, 0, 32'h1, got);
        #1;
        chk("r25_inhibited", counter_inc_o, 64'h0);
        event_i = 8'h00;
        tick();

        // Out-of-range index and select value
        csr(0, 2'd0, 5, 0, got);
        chk("r26_rdata", got, 64'h0);
        csr(1, 2'd1, 7, 32'hFFFF, got);
        csr(1, 2'd2, 4, 32'h2, got);
        csr(1, 2'd2, 0, 32'd15, got);
        csr(0, 2'd2, 0, 0, got);
        chk("r26_evsel_clamp", got, 64'h0);
        csr(1, 2'd3, 9, 32'hFFFF_FFFF, got);
        csr(0, 2'd3, 0, 0, got);
        chk("inhibit_mask", got, 64'h7);
        csr(1, 2'd3, 0, 32'h0, got);

        // Write wins over increment
        csr(1, 2'd2, 1, 32'd0, got);
        event_i = 8'h01;
        tick(); tick();
        chk("r27_before", counter_inc_o, 64'h7);
        csr(1, 2'd0, 1, 32'h55, got);
        chk("r27_during", last_inc, 64'h5);
        chk("r27_after", counter_inc_o, 64'h7);
        event_i = 8'h00;
        tick();

        // Reset during WRITE
        csr(1, 2'd2, 1, 32'd5, got);
        csr(1, 2'd3, 0, 32'h2, got);
        csr(0, 2'd2, 1, 0, got);
        chk("r28_evsel_set", got, 64'h5);
        csr_req_i = 1'b1; csr_we_i = 1'b1; csr_addr_i = 7'h00; csr_wdata_i = 32'h77;
        chk("r28_gnt", csr_gnt_o, 1);
        tick();
        csr_req_i = 1'b0;
        rst_i = 1'b1;
        #1;
        chk("r28_no_we", counter_we_o, 64'h0);
        tick();
        rst_i = 1'b0;
        for (int i = 0; i < NC; i++) m_evsel[i] = '0;
        m_inh = '0; m_shvld = 1'b0;
        chk("r28_gnt_after", csr_gnt_o, 1);
        chk("r28_no_rvalid", csr_rvalid_o, 0);
        tick();
        chk("r28_no_rvalid2", csr_rvalid_o, 0);
        csr(0, 2'd2, 1, 0, got);
        chk("r28_evsel", got, 64'h0);
        csr(0, 2'd3, 0, 0, got);
        chk("r28_inhibit", got, 64'h0);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hpm_counter_ctrl.md
HPM_COUNTER_CTRL -- requirements
Module: hpm_counter_ctrl

Interface
REQ-001 The block SHALL have parameter MaxNumCounters, default 29, meaning the counter-bank slot count (vector widths).
REQ-002 The block SHALL have parameter NumCounters, default 3, meaning the number of implemented counters (1..MaxNumCounters).
REQ-003 The block SHALL have parameter NumEvents, default 16, meaning the event input width (2..16).
REQ-004 The block SHALL have one clock and a synchronous, active-high reset; ports clk_i and rst_i.
REQ-005 The block SHALL have the following ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- csr_req_i  in  1  access request
- csr_we_i  in  1  1=write, 0=read
- csr_addr_i  in  7  [6:5] space (00 counter low, 01 counter high, 10 event select, 11 inhibit); [4:0] counter index
- csr_wdata_i  in  32  write data
- csr_gnt_o  out  1  request accepted
- csr_rvalid_o  out  1  response valid, one cycle
- csr_rdata_o  out  32  read data, valid with rvalid
- csr_err_o  out  1  access error, valid with rvalid
- event_i  in  NumEvents  per-cycle event strobes
- counter_rd_i  in  MaxNumCounters*64  bank values, slot i at [i*64+:64]
- counter_inc_o  out  MaxNumCounters  increment strobes to bank
- counter_we_o  out  MaxNumCounters  low-half write strobes
- counterh_we_o  out  MaxNumCounters  high-half write strobes
- counter_wval_o  out  32  write value to bank

Function
REQ-006 The FSM SHALL have states IDLE, WRITE, READ and RESP; csr_gnt_o = (state==IDLE), combinational.
REQ-007 In IDLE, a csr_req_i SHALL be accepted that cycle; the block SHALL latch we, addr and wdata and go to WRITE (we=1) or READ (we=0).
REQ-008 In WRITE (one cycle), the block SHALL perform the write and go to RESP; in READ (one cycle), it SHALL register csr_rdata_o and go to RESP.
REQ-009 In RESP (one cycle), csr_rvalid_o SHALL be 1 and the FSM SHALL return to IDLE; request-accept to rvalid latency is exactly 2 cycles; the next accept occurs no earlier than 3 cycles after the previous one.
REQ-010 An access with index >= NumCounters in spaces 00, 01 or 10 SHALL give csr_err_o=1 and csr_rdata_o=0, with no strobe and no register change; space 11 ignores the index and never errors.
REQ-011 A space-00 write SHALL pulse counter_we_o[idx] for the WRITE cycle only; a space-01 write SHALL pulse counterh_we_o[idx] likewise; counter_wval_o = latched wdata in WRITE and 0 otherwise.
REQ-012 A space-10 write SHALL set evsel[idx] = wdata[3:0]; a value >= NumEvents SHALL be stored as 0.
REQ-013 A space-11 write SHALL set inhibit[NumCounters-1:0] = wdata[NumCounters-1:0]; inhibit bits >= NumCounters SHALL be 0.
REQ-014 Reads SHALL return: space 00 -> counter_rd_i low 32 of idx; space 10 -> {28'b0, evsel[idx]}; space 11 -> inhibit zero-extended to 32.
REQ-015 Space-01 reads SHALL return the shadow if shadow_vld and shadow_idx==idx, otherwise the live high 32; the block SHALL clear shadow_vld on every space-01 read.
REQ-016 A space-00 read SHALL capture the high 32 of idx into shadow, set shadow_idx=idx and set shadow_vld=1; any counter write SHALL clear shadow_vld.
REQ-017 The block SHALL register counter_inc_o[i] each cycle: next = (i<NumCounters) & event_i[evsel[i]] & ~inhibit[i]; event-to-strobe latency is 1 cycle.
REQ-018 counter_inc_o[idx] SHALL be forced 0 in the cycle counter_we_o[idx] or counterh_we_o[idx] is high (write wins); other counters SHALL be unaffected.
REQ-019 Strobe outputs for slots >= NumCounters SHALL be constant 0.
REQ-020 An evsel or inhibit write SHALL take effect on counter_inc_o starting 2 cycles after the WRITE cycle (register update, then strobe register).

Reset
REQ-021 While rst_i=1 at a clock edge, the block SHALL set state=IDLE, all strobes=0, csr_rvalid_o=0, csr_err_o=0, csr_rdata_o=0, evsel[i]=0, inhibit=0, shadow_vld=0.
REQ-022 Reset asserted in WRITE SHALL suppress any strobe not yet issued; a transaction in progress SHALL be dropped with no rvalid; csr_gnt_o=1 in the first cycle after reset.

Verification
REQ-023 Write space 00, idx 1, wdata 0xDEADBEEF, accepted at cycle N -> counter_we_o=0b010 at N+1 only, counter_wval_o=0xDEADBEEF, rvalid at N+2 with err=0.
REQ-024 Read space 00, idx 2, bank slot 2=0x00000001_FFFFFFFF; bank then changes to 0x00000002_00000000; read space 01, idx 2 -> first rdata 0xFFFFFFFF, second 0x00000001; an immediate repeat of the space-01 read -> 0x00000002.
REQ-025 Set evsel[0]=3, inhibit=0; drive event_i[3]=1 for 5 cycles -> counter_inc_o[0]=1 for 5 cycles, delayed 1 cycle; then write inhibit=0x1 -> strobes stop 2 cycles after WRITE.
REQ-026 Read space 00, idx 5 with NumCounters=3 -> rvalid with err=1, rdata=0, no strobes; write evsel idx 0 = 15 with NumEvents=8 -> readback 0.
REQ-027 Hold event_i[0]=1 with evsel[1]=0 while writing idx 1 -> counter_inc_o[1]=0 exactly in the counter_we_o[1] cycle, 1 before and after.
REQ-028 Assert rst_i during WRITE -> no counter_we_o pulse, no rvalid; after release gnt=1, evsel and inhibit read back 0.
